spi_frm_seq: RTL and testbench
==============================

Name: spi_frm_seq

Overview:
SCLK-domain frame sequencer for the 24-bit SPI slave protocol (8b cmd, 8b data, 8b crc), supporting back-to-back frames within one CSB window. It tracks bit position and frame phase, and hands each completed RX frame to the i_clk domain through a toggle handshake. It schedules the MISO response word for each frame, sending either a fresh register-access response or a BUSY word. It sits between the SPI pads and the i_clk-domain frame decoder/CRC checker.

Parameters:
CMD_W, 8, command field width
DATA_W, 8, data field width
CRC_W, 8, crc field width
BUSY_WORD, 24'hFFFF00, MISO word sent when no fresh response exists (CRC deliberately invalid)
FRM_CNT_W, 4, width of the saturating frames-per-CSB counter

Ports:
i_spi_sclk  in  1  SPI clock; all state uses posedge except MISO launch on negedge
i_rst_n  in  1  asynchronous, active-low reset
i_spi_csb  in  1  chip select, low active; high = async clear of frame-position state only
i_spi_mosi  in  1  serial data in, MSB first
o_spi_miso  out  1  serial data out
o_frm_data  out  FRM_W  last accepted RX frame {cmd,data,crc}; stable while o_frm_tgl != ack
o_frm_tgl  out  1  toggles once per accepted frame
i_frm_ack_tgl  in  1  i_clk-domain ack toggle; synchronized in-block
i_rsp_data  in  FRM_W  response word; quasi-static while i_rsp_tgl != o_rsp_ack_tgl
i_rsp_tgl  in  1  toggles when i_rsp_data is fresh; synchronized in-block
o_rsp_ack_tgl  out  1  equals i_rsp_tgl value last consumed
o_phase  out  2  0=CMD, 1=DATA, 2=CRC
o_frm_cnt  out  FRM_CNT_W  frames completed in the current CSB window (saturating)
o_ovr_err  out  1  sticky; a frame completed before the previous one was acked
o_rsp_miss  out  1  sticky; a frame started with BUSY_WORD

Behaviour:
- FRM_W = CMD_W+DATA_W+CRC_W (localparam). bit_cnt is 0..FRM_W-1.
- Reset (i_rst_n=0): all outputs 0, including toggles and sync flops; bit_cnt=0; tx_word=BUSY_WORD; frm_data=0.
- CSB high (async): bit_cnt, shift reg, o_frm_cnt and o_spi_miso clear to 0. Toggles, o_frm_data, o_ovr_err and o_rsp_miss are held.
- Posedge while CSB low:
  - shift <= {shift[FRM_W-2:0], mosi}.
  - bit_cnt increments and wraps FRM_W-1 -> 0.
- Phase decode from bit_cnt: CMD for 0..CMD_W-1, DATA for the next DATA_W bits, CRC for the rest.
- Frame end (posedge with bit_cnt==FRM_W-1):
  - If ack_sync == o_frm_tgl: o_frm_data <= {shift[FRM_W-2:0], mosi}; o_frm_tgl flips.
  - Else: frame dropped, o_frm_data unchanged, o_ovr_err <= 1.
  - o_frm_cnt increments and saturates at all-ones.
- Frame start (posedge with bit_cnt==0):
  - If rsp_sync != o_rsp_ack_tgl: tx_word <= i_rsp_data; o_rsp_ack_tgl <= rsp_sync.
  - Else: tx_word <= BUSY_WORD; o_rsp_miss <= 1.
- MISO launch: on negedge, o_spi_miso <= tx_word[(FRM_W - bit_cnt) mod FRM_W].
  - tx MSB appears after the falling edge of bit 0; the LSB appears after the falling edge of the last bit.
  - The master samples on the following posedge; the first posedge of a window sees 0.
- Synchronizers: i_rsp_tgl and i_frm_ack_tgl each pass through a 2-flop posedge-SCLK sync. A response must be published at least 2 SCLK edges before frame start, otherwise BUSY is sent.
- Partial frame (CSB rises with bit_cnt != 0): discarded; no toggle; o_frm_cnt cleared.
- Simultaneous events:
  - Frame end plus ack arriving in the same cycle: the compare uses the pre-edge ack_sync value, so the frame is dropped.
  - Frame start and response toggle landing in the same cycle: the compare uses the current rsp_sync value.
- Sticky errors clear only on i_rst_n.

Decomposition:
- Package spi_frm_pkg holds:
  - CMD_W, DATA_W and CRC_W defaults, and the FRM_W derivation;
  - the phase enum spi_phase_e {PH_CMD, PH_DATA, PH_CRC};
  - the BUSY_WORD default.
- Sub-module spi_tgl_sync: 2-flop toggle synchronizer, reset 0, instanced twice.

Test Plan:
- Reset, one frame 24'h81_5A_C3, CSB high; i_frm_ack_tgl follows 10 SCLK later -> o_frm_tgl=1, o_frm_data=24'h815AC3, o_frm_cnt=1, o_phase returns to 0.
- i_rsp_data=24'h123456 and i_rsp_tgl=1 set before CSB falls, then a 24-bit frame -> MISO bits after falling edges 0..23 read 24'h123456, o_rsp_ack_tgl=1, o_rsp_miss=0.
- No response published, one frame -> MISO reads 24'hFFFF00, o_rsp_miss=1.
- Two back-to-back frames A=24'h010203 and B=24'h040506, no ack -> o_frm_data=24'h010203, o_ovr_err=1, o_frm_cnt=2, o_frm_tgl toggled once.
- Same two frames with ack toggled between them -> o_frm_data=24'h040506, two toggles, o_ovr_err=0.
- 13 bits, then CSB high, then a full frame 24'hAA55F0 -> only one toggle, o_frm_data=24'hAA55F0; a reset mid-frame zeroes all outputs.

Source files
------------

// File: rtl/spi_frm_pkg.sv
// rtl/spi_frm_pkg.sv - shared widths, phase encoding and BUSY word for the SPI frame sequencer
package spi_frm_pkg;

  localparam int CMD_W_DEF  = 8;
  localparam int DATA_W_DEF = 8;
  localparam int CRC_W_DEF  = 8;

  // Total frame length in bits for a given field split.
  function automatic int frm_width(input int cmd_w, input int data_w, input int crc_w);
    return cmd_w + data_w + crc_w;
  endfunction

  localparam int FRM_W_DEF = CMD_W_DEF + DATA_W_DEF + CRC_W_DEF;

  // Sent whenever no fresh response is available; its CRC byte is deliberately wrong.
  localparam logic [FRM_W_DEF-1:0] BUSY_WORD_DEF = 24'hFFFF00;

  typedef enum logic [1:0] {
    PH_CMD  = 2'd0,
    PH_DATA = 2'd1,
    PH_CRC  = 2'd2
  } spi_phase_e;

endpackage

// File: rtl/spi_tgl_sync.sv
// rtl/spi_tgl_sync.sv - two-flop synchronizer for a handshake toggle
module spi_tgl_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic tgl,
  output logic tgl_sync
);

  logic meta;

  // Two-stage capture; the second stage is the only one used by logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta     <= 1'b0;
      tgl_sync <= 1'b0;
    end else begin
      meta     <= tgl;
      tgl_sync <= meta;
    end
  end

endmodule

// File: rtl/spi_frm_seq.sv
// rtl/spi_frm_seq.sv - SCLK-domain SPI frame sequencer with toggle handoff and MISO scheduling
module spi_frm_seq
  import spi_frm_pkg::*;
#(
  parameter int                                CMD_W     = CMD_W_DEF,
  parameter int                                DATA_W    = DATA_W_DEF,
  parameter int                                CRC_W     = CRC_W_DEF,
  parameter logic [CMD_W+DATA_W+CRC_W-1:0]     BUSY_WORD = BUSY_WORD_DEF,
  parameter int                                FRM_CNT_W = 4
) (
  input  logic                            i_spi_sclk,
  input  logic                            i_rst_n,
  input  logic                            i_spi_csb,
  input  logic                            i_spi_mosi,
  output logic                            o_spi_miso,
  output logic [CMD_W+DATA_W+CRC_W-1:0]   o_frm_data,
  output logic                            o_frm_tgl,
  input  logic                            i_frm_ack_tgl,
  input  logic [CMD_W+DATA_W+CRC_W-1:0]   i_rsp_data,
  input  logic                            i_rsp_tgl,
  output logic                            o_rsp_ack_tgl,
  output logic [1:0]                      o_phase,
  output logic [FRM_CNT_W-1:0]            o_frm_cnt,
  output logic                            o_ovr_err,
  output logic                            o_rsp_miss
);

  localparam int FRM_W = frm_width(CMD_W, DATA_W, CRC_W);
  localparam int CNT_W = $clog2(FRM_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRM_W - 1);

  logic [CNT_W-1:0]     bit_cnt;
  // The oldest bit is never needed: on the last edge the full frame is
  // formed from these FRM_W-1 bits plus the live MOSI bit.
  logic [FRM_W-2:0]     shift;
  logic [FRM_CNT_W-1:0] frm_cnt;
  logic [FRM_W-1:0]     tx_word;
  logic [CNT_W-1:0]     tx_idx;
  logic                 ack_sync;
  logic                 rsp_sync;
  logic                 frm_start;
  logic                 frm_end;
  spi_phase_e           phase;

  spi_tgl_sync u_ack_sync (
    .clk      (i_spi_sclk),
    .rst_n    (i_rst_n),
    .tgl      (i_frm_ack_tgl),
    .tgl_sync (ack_sync)
  );

  spi_tgl_sync u_rsp_sync (
    .clk      (i_spi_sclk),
    .rst_n    (i_rst_n),
    .tgl      (i_rsp_tgl),
    .tgl_sync (rsp_sync)
  );

  assign frm_start = (bit_cnt == '0);
  assign frm_end   = (bit_cnt == LAST_BIT);

  // Field decode from the current bit position.
  always_comb begin
    phase = PH_CRC;
    if (bit_cnt < CNT_W'(CMD_W)) begin
      phase = PH_CMD;
    end else if (bit_cnt < CNT_W'(CMD_W + DATA_W)) begin
      phase = PH_DATA;
    end
  end

  assign o_phase = phase;

  // Frame position state; CSB high abandons any partial frame.
  always_ff @(posedge i_spi_sclk or negedge i_rst_n or posedge i_spi_csb) begin
    if (!i_rst_n) begin
      bit_cnt <= '0;
      shift   <= '0;
      frm_cnt <= '0;
    end else if (i_spi_csb) begin
      bit_cnt <= '0;
      shift   <= '0;
      frm_cnt <= '0;
    end else begin
      shift   <= {shift[FRM_W-3:0], i_spi_mosi};
      bit_cnt <= frm_end ? '0 : bit_cnt + 1'b1;
      if (frm_end && (frm_cnt != {FRM_CNT_W{1'b1}})) begin
        frm_cnt <= frm_cnt + 1'b1;
      end
    end
  end

  assign o_frm_cnt = frm_cnt;

  // RX handoff: publish a completed frame only if the previous one was acked.
  always_ff @(posedge i_spi_sclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_frm_data <= '0;
      o_frm_tgl  <= 1'b0;
      o_ovr_err  <= 1'b0;
    end else if (!i_spi_csb && frm_end) begin
      if (ack_sync == o_frm_tgl) begin
        o_frm_data <= {shift, i_spi_mosi};
        o_frm_tgl  <= ~o_frm_tgl;
      end else begin
        o_ovr_err  <= 1'b1;
      end
    end
  end

  // TX scheduling: latch a fresh response at frame start, otherwise BUSY.
  always_ff @(posedge i_spi_sclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tx_word       <= BUSY_WORD;
      o_rsp_ack_tgl <= 1'b0;
      o_rsp_miss    <= 1'b0;
    end else if (!i_spi_csb && frm_start) begin
      if (rsp_sync != o_rsp_ack_tgl) begin
        tx_word       <= i_rsp_data;
        o_rsp_ack_tgl <= rsp_sync;
      end else begin
        tx_word       <= BUSY_WORD;
        o_rsp_miss    <= 1'b1;
      end
    end
  end

  // bit_cnt has already advanced past the bit just clocked, so bit k of the
  // frame launches tx bit FRM_W-1-k; position 0 wraps to the LSB.
  assign tx_idx = frm_start ? '0 : CNT_W'(FRM_W) - bit_cnt;

  // MISO launched on the falling edge so the master samples it on the next rise.
  always_ff @(negedge i_spi_sclk or negedge i_rst_n or posedge i_spi_csb) begin
    if (!i_rst_n) begin
      o_spi_miso <= 1'b0;
    end else if (i_spi_csb) begin
      o_spi_miso <= 1'b0;
    end else begin
      o_spi_miso <= tx_word[tx_idx];
    end
  end

endmodule

// File: tb/tb_spi_frm_seq.sv
// tb/tb_spi_frm_seq.sv - self-checking bench for spi_frm_seq with a frame-level reference model
module tb_spi_frm_seq;

  localparam int          W    = 24;
  localparam logic [23:0] BUSY = 24'hFFFF00;

  logic        i_spi_sclk;
  logic        i_rst_n;
  logic        i_spi_csb;
  logic        i_spi_mosi;
  logic        o_spi_miso;
  logic [23:0] o_frm_data;
  logic        o_frm_tgl;
  logic        i_frm_ack_tgl;
  logic [23:0] i_rsp_data;
  logic        i_rsp_tgl;
  logic        o_rsp_ack_tgl;
  logic [1:0]  o_phase;
  logic [3:0]  o_frm_cnt;
  logic        o_ovr_err;
  logic        o_rsp_miss;

  int total = 0;
  int bad   = 0;

  // Reference model: frame-level view of what the block must have done.
  logic        m_tgl, m_ovr, m_miss, m_rsp_ack, m_pend, m_rsp_tgl;
  logic [23:0] m_data, m_rsp_word;
  int          m_cnt;

  spi_frm_seq dut (
    .i_spi_sclk    (i_spi_sclk),
    .i_rst_n       (i_rst_n),
    .i_spi_csb     (i_spi_csb),
    .i_spi_mosi    (i_spi_mosi),
    .o_spi_miso    (o_spi_miso),
    .o_frm_data    (o_frm_data),
    .o_frm_tgl     (o_frm_tgl),
    .i_frm_ack_tgl (i_frm_ack_tgl),
    .i_rsp_data    (i_rsp_data),
    .i_rsp_tgl     (i_rsp_tgl),
    .o_rsp_ack_tgl (o_rsp_ack_tgl),
    .o_phase       (o_phase),
    .o_frm_cnt     (o_frm_cnt),
    .o_ovr_err     (o_ovr_err),
    .o_rsp_miss    (o_rsp_miss)
  );

  initial begin
    i_spi_sclk = 1'b0;
    forever #5 i_spi_sclk = ~i_spi_sclk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  function automatic logic [1:0] phase_of(input int pos);
    if (pos < 8)  return 2'd0;
    if (pos < 16) return 2'd1;
    return 2'd2;
  endfunction

  task automatic model_reset();
    m_tgl = 0; m_ovr = 0; m_miss = 0; m_rsp_ack = 0; m_pend = 0; m_rsp_tgl = 0;
    m_data = '0; m_rsp_word = '0; m_cnt = 0;
  endtask

  task automatic do_reset();
    i_rst_n = 0; i_spi_csb = 1; i_spi_mosi = 0;
    i_frm_ack_tgl = 0; i_rsp_tgl = 0; i_rsp_data = '0;
    model_reset();
    @(negedge i_spi_sclk); #1;
    i_rst_n = 1;
    repeat (3) @(negedge i_spi_sclk);
    #1;
  endtask

  task automatic publish(input logic [23:0] w);
    i_rsp_data = w;
    i_rsp_tgl  = ~i_rsp_tgl;
    m_rsp_word = w;
    m_rsp_tgl  = i_rsp_tgl;
    m_pend     = 1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge i_spi_sclk);
    #1;
  endtask

  task automatic open_window();
    total++;
    if (o_spi_miso !== 1'b0) begin
      bad++; $display("FAIL miso_idle: got %b want 0", o_spi_miso);
    end
    i_spi_csb = 0;
  endtask

  task automatic close_window(input int n);
    i_spi_csb = 1;
    m_cnt = 0;
    #1;
    total++;
    if (o_frm_cnt !== 4'd0 || o_phase !== 2'd0 || o_spi_miso !== 1'b0) begin
      bad++; $display("FAIL csb_clear: got cnt=%0d ph=%0d miso=%b want 0 0 0", o_frm_cnt, o_phase, o_spi_miso);
    end
    idle(n);
  endtask

  // Drives nbits of w (MSB first) from the current bit position 0, checks phase
  // and every MISO bit, then compares the frame-level state with the model.
  task automatic send_frame(input logic [23:0] w, input int nbits, input bit ack_mid,
                            input bit pub_mid, input logic [23:0] pub_w, output logic [23:0] rx);
    logic [23:0] tx_exp;
    if (m_pend) begin
      tx_exp = m_rsp_word; m_rsp_ack = m_rsp_tgl; m_pend = 0;
    end else begin
      tx_exp = BUSY; m_miss = 1;
    end
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      i_spi_mosi = w[23-i];
      total++;
      if (o_phase !== phase_of(i)) begin
        bad++; $display("FAIL phase bit%0d: got %0d want %0d", i, o_phase, phase_of(i));
      end
      if (i == 5 && ack_mid) i_frm_ack_tgl = m_tgl;
      if (i == 5 && pub_mid && !m_pend) publish(pub_w);
      @(posedge i_spi_sclk);
      @(negedge i_spi_sclk); #1;
      rx[23-i] = o_spi_miso;
      total++;
      if (o_spi_miso !== tx_exp[23-i]) begin
        bad++; $display("FAIL miso bit%0d: got %b want %b", i, o_spi_miso, tx_exp[23-i]);
      end
    end
    if (nbits == W) begin
      if (i_frm_ack_tgl == m_tgl) begin
        m_data = w; m_tgl = ~m_tgl;
      end else begin
        m_ovr = 1;
      end
      if (m_cnt < 15) m_cnt++;
    end
    total++;
    if (o_frm_data !== m_data || o_frm_tgl !== m_tgl || o_ovr_err !== m_ovr || o_rsp_miss !== m_miss ||
        o_rsp_ack_tgl !== m_rsp_ack || o_frm_cnt !== 4'(m_cnt)) begin
      bad++;
      $display("FAIL frame_state: got data=%h tgl=%b ovr=%b miss=%b ack=%b cnt=%0d want data=%h tgl=%b ovr=%b miss=%b ack=%b cnt=%0d",
               o_frm_data, o_frm_tgl, o_ovr_err, o_rsp_miss, o_rsp_ack_tgl, o_frm_cnt,
               m_data, m_tgl, m_ovr, m_miss, m_rsp_ack, m_cnt);
    end
  endtask

  task automatic test_reset();
    i_rst_n = 0; i_spi_csb = 1; i_spi_mosi = 0;
    i_frm_ack_tgl = 0; i_rsp_tgl = 0; i_rsp_data = '0;
    model_reset();
    @(negedge i_spi_sclk); #1;
    total++;
    if ({o_spi_miso, o_frm_data, o_frm_tgl, o_rsp_ack_tgl, o_phase, o_frm_cnt, o_ovr_err, o_rsp_miss} !== '0) begin
      bad++; $display("FAIL reset_outputs: got data=%h tgl=%b cnt=%0d want all zero", o_frm_data, o_frm_tgl, o_frm_cnt);
    end
    i_rst_n = 1;
    idle(3);
  endtask

  task automatic test_response();
    logic [23:0] rx;
    do_reset();
    publish(24'h123456);
    idle(4);
    open_window();
    send_frame(24'h0A0B0C, W, 0, 0, '0, rx);
    total++;
    if (rx !== 24'h123456 || o_rsp_ack_tgl !== 1'b1 || o_rsp_miss !== 1'b0) begin
      bad++; $display("FAIL response: got rx=%h ack=%b miss=%b want 123456 1 0", rx, o_rsp_ack_tgl, o_rsp_miss);
    end
    close_window(3);
  endtask

  task automatic test_busy();
    logic [23:0] rx;
    do_reset();
    open_window();
    send_frame(24'h777777, W, 0, 0, '0, rx);
    total++;
    if (rx !== 24'hFFFF00 || o_rsp_miss !== 1'b1) begin
      bad++; $display("FAIL busy: got rx=%h miss=%b want ffff00 1", rx, o_rsp_miss);
    end
    close_window(3);
  endtask

  // A response toggled right at the first edge is too late for that frame but
  // must be delivered on the following one.
  task automatic test_late_rsp();
    logic [23:0] rx;
    do_reset();
    open_window();
    i_rsp_data = 24'hC0FFEE;
    i_rsp_tgl  = 1;
    send_frame(24'h111111, W, 1, 0, '0, rx);
    total++;
    if (rx !== BUSY) begin
      bad++; $display("FAIL late_rsp_busy: got %h want %h", rx, BUSY);
    end
    m_pend = 1; m_rsp_word = 24'hC0FFEE; m_rsp_tgl = 1;
    send_frame(24'h222222, W, 1, 0, '0, rx);
    total++;
    if (rx !== 24'hC0FFEE || o_rsp_ack_tgl !== 1'b1) begin
      bad++; $display("FAIL late_rsp_next: got rx=%h ack=%b want c0ffee 1", rx, o_rsp_ack_tgl);
    end
    close_window(3);
  endtask

  task automatic test_single_frame();
    logic [23:0] rx;
    do_reset();
    open_window();
    send_frame(24'h815AC3, W, 0, 0, '0, rx);
    total++;
    if (o_frm_cnt !== 4'd1 || o_phase !== 2'd0) begin
      bad++; $display("FAIL single_cnt: got cnt=%0d ph=%0d want 1 0", o_frm_cnt, o_phase);
    end
    close_window(2);
    i_frm_ack_tgl = m_tgl;
    idle(10);
    total++;
    if (o_frm_tgl !== 1'b1 || o_frm_data !== 24'h815AC3 || o_phase !== 2'd0) begin
      bad++; $display("FAIL single_frame: got tgl=%b data=%h ph=%0d want 1 815ac3 0", o_frm_tgl, o_frm_data, o_phase);
    end
    open_window();
    send_frame(24'h00003C, W, 0, 0, '0, rx);
    total++;
    if (o_frm_tgl !== 1'b0 || o_frm_data !== 24'h00003C || o_ovr_err !== 1'b0) begin
      bad++; $display("FAIL after_ack: got tgl=%b data=%h ovr=%b want 0 00003c 0", o_frm_tgl, o_frm_data, o_ovr_err);
    end
    close_window(3);
  endtask

  task automatic test_back_to_back();
    logic [23:0] rx;
    do_reset();
    open_window();
    send_frame(24'h010203, W, 0, 0, '0, rx);
    send_frame(24'h040506, W, 0, 0, '0, rx);
    total++;
    if (o_frm_data !== 24'h010203 || o_ovr_err !== 1'b1 || o_frm_cnt !== 4'd2 || o_frm_tgl !== 1'b1) begin
      bad++; $display("FAIL b2b_noack: got data=%h ovr=%b cnt=%0d tgl=%b want 010203 1 2 1", o_frm_data, o_ovr_err, o_frm_cnt, o_frm_tgl);
    end
    close_window(3);
  endtask

  task automatic test_back_to_back_ack();
    logic [23:0] rx;
    do_reset();
    open_window();
    send_frame(24'h010203, W, 0, 0, '0, rx);
    send_frame(24'h040506, W, 1, 0, '0, rx);
    total++;
    if (o_frm_data !== 24'h040506 || o_ovr_err !== 1'b0 || o_frm_cnt !== 4'd2 || o_frm_tgl !== 1'b0) begin
      bad++; $display("FAIL b2b_ack: got data=%h ovr=%b cnt=%0d tgl=%b want 040506 0 2 0", o_frm_data, o_ovr_err, o_frm_cnt, o_frm_tgl);
    end
    close_window(3);
  endtask

  task automatic test_partial();
    logic [23:0] rx;
    do_reset();
    open_window();
    send_frame(24'h5F5F5F, 13, 0, 0, '0, rx);
    close_window(3);
    open_window();
    send_frame(24'hAA55F0, W, 0, 0, '0, rx);
    total++;
    if (o_frm_tgl !== 1'b1 || o_frm_data !== 24'hAA55F0) begin
      bad++; $display("FAIL partial: got tgl=%b data=%h want 1 aa55f0", o_frm_tgl, o_frm_data);
    end
    close_window(3);
  endtask

  task automatic test_saturate();
    logic [23:0] rx;
    do_reset();
    open_window();
    for (int f = 0; f < 17; f++) begin
      send_frame(24'(f * 24'h010101), W, 1, 0, '0, rx);
    end
    total++;
    if (o_frm_cnt !== 4'hF || o_ovr_err !== 1'b0) begin
      bad++; $display("FAIL saturate: got cnt=%0d ovr=%b want 15 0", o_frm_cnt, o_ovr_err);
    end
    close_window(3);
  endtask

  task automatic test_random();
    logic [23:0] rx;
    int nf, nb;
    do_reset();
    for (int wdw = 0; wdw < 12; wdw++) begin
      if ($urandom_range(0, 1) == 1 && !m_pend) publish(24'($urandom));
      if ($urandom_range(0, 1) == 1) i_frm_ack_tgl = m_tgl;
      idle(4);
      open_window();
      nf = $urandom_range(1, 3);
      for (int f = 0; f < nf; f++) begin
        nb = (f == nf - 1 && $urandom_range(0, 3) == 0) ? $urandom_range(1, 23) : W;
        send_frame(24'($urandom), nb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 24'($urandom), rx);
      end
      close_window(2);
    end
  endtask

  task automatic test_reset_mid();
    logic [23:0] rx;
    do_reset();
    open_window();
    send_frame(24'h5A5A5A, W, 0, 0, '0, rx);
    send_frame(24'hF0F0F0, 10, 0, 0, '0, rx);
    i_rst_n = 0;
    #1;
    total++;
    if ({o_spi_miso, o_frm_data, o_frm_tgl, o_rsp_ack_tgl, o_phase, o_frm_cnt, o_ovr_err, o_rsp_miss} !== '0) begin
      bad++; $display("FAIL reset_mid: got data=%h tgl=%b miss=%b cnt=%0d want all zero", o_frm_data, o_frm_tgl, o_rsp_miss, o_frm_cnt);
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_response();
    test_busy();
    test_late_rsp();
    test_single_frame();
    test_back_to_back();
    test_back_to_back_ack();
    test_partial();
    test_saturate();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
